// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_framer
// Description : UART transmit framer. It sends a start bit, then DATA_BITS
//               data bits LSB first, an optional odd/even parity bit, and
//               STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clocks.
//               A frame starts only while the receiver asserts rts.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_framer #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 send,
  input  logic                 rts,
  output logic                 busy,
  output logic                 done,
  output logic                 tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  // The parity bit sits above the data bits, so once every data bit has been
  // shifted out the parity bit is at position 0.
  logic [DATA_BITS:0]    shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  parity_bit;
  logic                  bit_end;

  generate
    if (PARITY == 1) begin : g_parity_odd
      assign parity_bit = ~^data;
    end else if (PARITY == 2) begin : g_parity_even
      assign parity_bit = ^data;
    end else begin : g_parity_none
      assign parity_bit = 1'b1;
    end
  endgenerate

  // Next-state logic: bit timing, state sequencing and shift register updates.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    bit_end = (baud_q == BAUD_LAST);

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (send && rts) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          shift_d = {parity_bit, data};
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b1, shift_q[DATA_BITS:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are derived from the next state so the registered line changes
    // in the same cycle the state does.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  // State and output registers; reset overrides any acceptance in that cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868, clocks per bit period; legal range 2..65535.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port data  input  DATA_BITS  byte to send; sampled only at frame acceptance.
REQ-008 SHALL have port send  input  1  host request to start a frame.
REQ-009 SHALL have port rts  input  1  receiver ready; a frame starts only while high.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress.
REQ-011 SHALL have port done  output  1  one-clock pulse on frame completion.
REQ-012 SHALL have port tx  output  1  serial line, registered, idle high.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PAR, STOP.
REQ-014 SHALL accept a frame in IDLE when send=1 and rts=1 at a rising edge: latch data and parity into a shift register, enter START, zero the baud and bit counters.
REQ-015 SHALL drive tx low in START, data bits LSB first in DATA, the parity bit in PAR, and high in STOP; each bit lasts exactly CLKS_PER_BIT clocks.
REQ-016 SHALL go from START to DATA after one bit period.
REQ-017 SHALL go from DATA to PAR (PARITY!=0) or STOP (PARITY=0) after DATA_BITS periods, shifting the register once per period.
REQ-018 SHALL go from PAR to STOP after one period.
REQ-019 SHALL go from STOP to IDLE after STOP_BITS periods.
REQ-020 SHALL compute the parity bit from the latched data: even = XOR of bits; odd = inverted XOR.
REQ-021 SHALL make total frame length (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT clocks, from the first tx-low cycle to the first IDLE cycle.
REQ-022 SHALL make the baud counter $clog2(CLKS_PER_BIT) bits wide, counting 0..CLKS_PER_BIT-1 and wrapping to 0 at each bit boundary; the bit counter wraps the same way.
REQ-023 SHALL assert busy=1 in every non-IDLE state; busy rises the clock after acceptance, together with tx=0.
REQ-024 SHALL assert done=1 for exactly the first IDLE cycle after STOP; busy=0 in that cycle.
REQ-025 SHALL allow acceptance in the done cycle if send=1 and rts=1, so with send held high consecutive frames have one idle-high clock between them.
REQ-026 SHALL keep tx high and leave data, send and rts without effect in IDLE unless the acceptance condition holds.
REQ-027 SHALL ignore rts, send and data changes once a frame is accepted; rts falling mid-frame does not abort the frame.

Reset
REQ-028 SHALL, at a rising edge with reset=1, force state IDLE, tx=1, busy=0, done=0, and clear the counters and shift register, including mid-frame.
REQ-029 SHALL give reset priority over acceptance in the same cycle.
REQ-030 SHALL not accept any frame in the cycle reset is high; acceptance is possible from the first cycle after reset falls.

Verification
REQ-031 SHALL cover: CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2, STOP_BITS=1, send 0xA5 -> tx, each bit 4 clocks: 0,1,0,1,0,0,1,0,1,0(par),1; busy high 44 clocks; single done pulse.
REQ-032 SHALL cover: PARITY=1, data 0x00 -> parity bit 1; data 0x01 -> parity bit 0.
REQ-033 SHALL cover: rts=0, send=1 for 20 clocks -> tx stays 1, busy 0; rts rises -> frame starts the next clock.
REQ-034 SHALL cover: send held high, two frames -> exactly one idle-high clock between frames; the second frame carries the data present at its acceptance edge.
REQ-035 SHALL cover: reset during bit 3 of DATA -> next clock tx=1, busy=0, done=0; no done pulse.
REQ-036 SHALL cover: DATA_BITS=7, PARITY=0, STOP_BITS=2, CLKS_PER_BIT=3 -> frame lasts 30 clocks, with 6 high clocks before done.
